serial_ripple_subtractor: RTL and testbench

//  Multi-cycle bit-serial subtractor. Computes diff = a - b - bin over WIDTH

---
 rtl/serial_ripple_subtractor.sv | 157 +++++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// serial_ripple_subtractor
//
// Bit-serial subtractor: diff = a - b - bin (unsigned, modulo 2^WIDTH), one
// full-subtractor bit per clock, LSB first, with the borrow held in a register
// between bits. Trades latency (WIDTH+1 cycles per result) for a single
// full-subtractor cell instead of a WIDTH-bit ripple chain.
//
// Handshake: start_i is sampled while the block is not busy (IDLE or the
// single DONE cycle). done_o pulses for one cycle when diff_o/bout_o are
// updated; those outputs then hold until the next done_o or a reset.
//
// Ports
//   clk_i    in   1      clock, rising edge
//   rst_i    in   1      asynchronous, active-high reset (aborts any operation)
//   start_i  in   1      operation request, ignored while busy_o=1
//   a_i      in   WIDTH  minuend, captured on an accepted start
//   b_i      in   WIDTH  subtrahend, captured on an accepted start
//   bin_i    in   1      borrow-in, captured on an accepted start
//   busy_o   out  1      high while bits are being processed
//   done_o   out  1      one-cycle pulse: diff_o/bout_o just became valid
//   diff_o   out  WIDTH  a - b - bin modulo 2^WIDTH
//   bout_o   out  1      borrow-out, 1 when a < b + bin
// -----------------------------------------------------------------------------
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
);

  // Bit counter only has to reach WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // One-bit full subtractor, returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bw);
    logic d;
    logic bo;
    d  = x ^ y ^ bw;
    bo = (~x & y) | (~(x ^ y) & bw);
    full_sub = {bo, d};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operands are shifted right each bit, so the bit under work is always at [0].
  logic [1:0] fs_bit;
  assign fs_bit = full_sub(a_q[0], b_q[0], br_q);

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      // DONE accepts a new request exactly like IDLE (back-to-back operation).
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = bin_i;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = fs_bit[1];
        // Result bits enter at the MSB; after WIDTH bits bit 0 sits at [0].
        res_d = {fs_bit[0], res_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          // Counter holds at WIDTH-1 instead of wrapping.
          state_d = ST_DONE;
          diff_d  = {fs_bit[0], res_q[WIDTH-1:1]};
          bout_d  = fs_bit[1];
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered alongside the state they describe.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: a WIDTH=4 and a WIDTH=8 instance, a
// cycle-level reference model, and directed hand-computed cases.
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = 4'd0, b4 = 4'd0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  serial_ripple_subtractor #(.WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4), .bin_i(bin4),
    .busy_o(busy4), .done_o(done4), .diff_o(diff4), .bout_o(bout4));

  serial_ripple_subtractor #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
    .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: operation accepted when idle-or-done and start=1; result
  // {bout,diff} = {0,a}-{0,b}-bin mod 2^(W+1); busy for W cycles, then done.
  logic       m_start[2];
  logic [8:0] m_ref[2];
  logic [4:0] ref4;
  logic [8:0] ref8;
  assign ref4 = {1'b0, a4} - {1'b0, b4} - {4'd0, bin4};
  assign ref8 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
  assign m_start[0] = start4;
  assign m_start[1] = start8;
  assign m_ref[0]   = {4'd0, ref4};
  assign m_ref[1]   = ref8;

  int         rem[2];
  logic       mbusy[2], mdone[2];
  logic [8:0] pend[2], held[2];

  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        rem[j] <= 0; mbusy[j] <= 1'b0; mdone[j] <= 1'b0;
        pend[j] <= 9'd0; held[j] <= 9'd0;
      end else if (rem[j] > 0) begin
        rem[j]   <= rem[j] - 1;
        mbusy[j] <= (rem[j] > 1);
        mdone[j] <= (rem[j] == 1);
        if (rem[j] == 1) held[j] <= pend[j];
      end else if (m_start[j]) begin
        rem[j]   <= (j == 0) ? 4 : 8;
        pend[j]  <= m_ref[j];
        mbusy[j] <= 1'b1;
        mdone[j] <= 1'b0;
      end else begin
        mbusy[j] <= 1'b0;
        mdone[j] <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy4", {8'd0, busy4}, {8'd0, mbusy[0]});
      chk("done4", {8'd0, done4}, {8'd0, mdone[0]});
      chk("res4",  {4'd0, bout4, diff4}, held[0]);
      chk("busy8", {8'd0, busy8}, {8'd0, mbusy[1]});
      chk("done8", {8'd0, done8}, {8'd0, mdone[1]});
      chk("res8",  {bout8, diff8}, held[1]);
    end
  end

  // One WIDTH=4 operation: start pulsed one cycle, wait (bounded) for done.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                     output int lat, output int busyc,
                     output logic [3:0] d, output logic bo);
    logic ok;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; bin4 = bi;
    lat = 0; busyc = 0; ok = 1'b0; d = 4'd0; bo = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy4) busyc++;
      if (done4) begin
        ok = 1'b1; lat = i; d = diff4; bo = bout4;
        break;
      end
      if (i == 1) start4 = 1'b0;
    end
    start4 = 1'b0;
    if (!ok) chk("op4_timeout", 9'd0, 9'd1);
  endtask

  int         lat, busyc, ndone, t1, t2;
  logic [3:0] d;
  logic       bo;
  logic       ok8;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy4", {8'd0, busy4}, 9'd0);
    chk("rst_done4", {8'd0, done4}, 9'd0);
    chk("rst_res4",  {4'd0, bout4, diff4}, 9'd0);
    chk("rst_res8",  {bout8, diff8}, 9'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 9-3: latency and busy length
    op4(4'd9, 4'd3, 1'b0, lat, busyc, d, bo);
    chk("t1_latency", 9'(lat), 9'd5);
    chk("t1_busy_cycles", 9'(busyc), 9'd4);
    chk("t1_diff", {8'd0, bo, d} >> 0, {4'd0, 1'b0, 4'h6});

    // borrow cases
    op4(4'd3, 4'd9, 1'b0, lat, busyc, d, bo);
    chk("t2_3m9", {4'd0, bo, d}, {4'd0, 1'b1, 4'hA});
    op4(4'd0, 4'd0, 1'b1, lat, busyc, d, bo);
    chk("t2_0m0m1", {4'd0, bo, d}, {4'd0, 1'b1, 4'hF});
    op4(4'd6, 4'd6, 1'b1, lat, busyc, d, bo);
    chk("t2_aeqb_bin", {4'd0, bo, d}, {4'd0, 1'b1, 4'hF});

    // start and operands disturbed during SHIFT: 5-2-1 = 2
    @(negedge clk); start4 = 1'b1; a4 = 4'd5; b4 = 4'd2; bin4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); start4 = 1'b1; a4 = 4'd0; b4 = 4'd15; bin4 = 1'b0;
    @(negedge clk); start4 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done4) begin ndone++; d = diff4; bo = bout4; end
    end
    chk("t3_done_count", 9'(ndone), 9'd1);
    chk("t3_result", {4'd0, bo, d}, {4'd0, 1'b0, 4'h2});

    // async reset in the 2nd SHIFT cycle
    @(negedge clk); start4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0;
    @(negedge clk); start4 = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("t4_busy_now", {8'd0, busy4}, 9'd0);
    chk("t4_done_now", {8'd0, done4}, 9'd0);
    chk("t4_res_now",  {4'd0, bout4, diff4}, 9'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("t4_no_done", 9'(ndone), 9'd0);
    op4(4'd12, 4'd5, 1'b0, lat, busyc, d, bo);
    chk("t4_after", {4'd0, bo, d}, {4'd0, 1'b0, 4'h7});

    // start held high: 7-2 then 1-1-1
    @(negedge clk); start4 = 1'b1; a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0;
    @(negedge clk); a4 = 4'd1; b4 = 4'd1; bin4 = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done4 && t1 < 0) begin
        t1 = i;
        chk("t5_first", {4'd0, bout4, diff4}, {4'd0, 1'b0, 4'h5});
      end else if (done4) begin
        t2 = i;
        chk("t5_second", {4'd0, bout4, diff4}, {4'd0, 1'b1, 4'hF});
        start4 = 1'b0;
        break;
      end
    end
    start4 = 1'b0;
    chk("t5_spacing", 9'(t2 - t1), 9'd5);
    repeat (3) @(negedge clk);

    // exhaustive WIDTH=4 alongside random WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start4 = (i < 512);
      {a4, b4, bin4} = 9'(i);
      start8 = 1'b1;
      if (i == 0) begin
        a8 = 8'h10; b8 = 8'h20; bin8 = 1'b1;
      end else if (i == 1) begin
        a8 = 8'hA5; b8 = 8'hA5; bin8 = 1'b1;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      @(negedge clk);
      start4 = 1'b0; start8 = 1'b0;
      ok8 = 1'b0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (done8) begin ok8 = 1'b1; break; end
      end
      if (!ok8) chk("t6_timeout", 9'd0, 9'd1);
      if (i == 0) chk("t6_w8_lit", {bout8, diff8}, {1'b1, 8'hEF});
      if (i == 1) chk("t6_w8_aeqb", {bout8, diff8}, {1'b1, 8'hFF});
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
